// File: rtl/i2c_eeprom_slave.sv
// I2C target emulating an AT24C08-style 1 KB EEPROM (block select in the device
// address, 16-byte page writes, sequential and current-address reads).
module i2c_eeprom_slave #(
  parameter logic [4:0]  DEVADR_HI = 5'b10100,
  parameter int unsigned PAGE_BITS = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  inout  wire        scl,
  inout  wire        sda,
  output logic [9:0] mem_adr_o,
  output logic [7:0] mem_dat_o,
  output logic       mem_we_o,
  input  logic [7:0] mem_dat_i,
  output logic       busy_o,
  output logic       wr_done_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEVADR, S_DEVACK, S_WADR, S_WADRACK,
    S_WDATA, S_WDACK, S_RDATA, S_RDACK
  } state_e;

  localparam logic [PAGE_BITS-1:0] PAGE_STEP = PAGE_BITS'(1);

  state_e     state_q;
  logic [2:0] scl_sync_q, sda_sync_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q, tx_q, mem_dat_q;
  logic [9:0] ptr_q;
  logic       rnw_q, ack_q, sda_oe_q, mem_we_q, busy_q, wr_done_q, wrote_q;

  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, byte_done;
  logic [9:0] ptr_page_inc;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_sync_q[2];
  assign scl_fall  = ~scl_s & scl_sync_q[2];
  assign start_det = scl_s & scl_sync_q[2] & sda_sync_q[2] & ~sda_s;
  assign stop_det  = scl_s & scl_sync_q[2] & ~sda_sync_q[2] & sda_s;
  assign byte_done = scl_fall && (bit_cnt_q == 4'd8);

  // Page writes wrap inside the page; the upper pointer bits never move.
  assign ptr_page_inc = {ptr_q[9:PAGE_BITS], ptr_q[PAGE_BITS-1:0] + PAGE_STEP};

  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge values; synchronizers reset to 1 so an idle bus gives no false START.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      tx_q       <= 8'd0;
      mem_dat_q  <= 8'd0;
      ptr_q      <= 10'd0;
      rnw_q      <= 1'b0;
      ack_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_done_q  <= 1'b0;
      wrote_q    <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl};
      sda_sync_q <= {sda_sync_q[1:0], sda};
      mem_we_q   <= 1'b0;
      wr_done_q  <= 1'b0;
      if (mem_we_q) ptr_q <= ptr_page_inc;

      if (start_det) begin
        state_q   <= S_DEVADR;
        bit_cnt_q <= 4'd0;
        sda_oe_q  <= 1'b0;
        wrote_q   <= 1'b0;
      end else if (stop_det) begin
        state_q   <= S_IDLE;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        wr_done_q <= wrote_q;
        wrote_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_DEVADR, S_WADR, S_WDATA: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (byte_done) begin
              bit_cnt_q <= 4'd0;
              sda_oe_q  <= 1'b1;
              if (state_q == S_DEVADR) begin
                if (shift_q[7:3] == DEVADR_HI) begin
                  ptr_q[9:8] <= shift_q[2:1];
                  rnw_q      <= shift_q[0];
                  busy_q     <= 1'b1;
                  state_q    <= S_DEVACK;
                end else begin
                  sda_oe_q <= 1'b0;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
                end
              end else if (state_q == S_WADR) begin
                ptr_q[7:0] <= shift_q;
                state_q    <= S_WADRACK;
              end else begin
                mem_dat_q <= shift_q;
                mem_we_q  <= 1'b1;
                wrote_q   <= 1'b1;
                state_q   <= S_WDACK;
              end
            end
          end
          S_DEVACK: begin
            if (scl_fall) begin
              bit_cnt_q <= 4'd0;
              if (rnw_q) begin
                tx_q     <= mem_dat_i;
                ptr_q    <= ptr_q + 10'd1;
                sda_oe_q <= ~mem_dat_i[7];
                state_q  <= S_RDATA;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= S_WADR;
              end
            end
          end
          S_WADRACK, S_WDACK: begin
            if (scl_fall) begin
              bit_cnt_q <= 4'd0;
              sda_oe_q  <= 1'b0;
              state_q   <= S_WDATA;
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (byte_done) begin
              sda_oe_q <= 1'b0;
              state_q  <= S_RDACK;
            end else if (scl_fall) begin
              tx_q     <= {tx_q[6:0], 1'b0};
              sda_oe_q <= ~tx_q[6];
            end
          end
          S_RDACK: begin
            if (scl_rise) begin
              ack_q <= sda_s;
            end else if (scl_fall) begin
              bit_cnt_q <= 4'd0;
              if (!ack_q) begin
                tx_q     <= mem_dat_i;
                ptr_q    <= ptr_q + 10'd1;
                sda_oe_q <= ~mem_dat_i[7];
                state_q  <= S_RDATA;
              end else begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign mem_adr_o = ptr_q;
  assign mem_dat_o = mem_dat_q;
  assign mem_we_o  = mem_we_q;
  assign busy_o    = busy_q;
  assign wr_done_o = wr_done_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bit-banged I2C master driving i2c_eeprom_slave; a scoreboard checks memory
// writes and read bytes against an EEPROM model (byte array plus pointer rules).
module tb_i2c_eeprom_slave;

  localparam int         Q      = 6;        // clocks per quarter SCL period
  localparam int         PAGE   = 16;
  localparam logic [4:0] DEV_HI = 5'b10100;

  typedef struct {
    int         adr;
    logic [7:0] dat;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        scl_w;
  wire        sda_w;
  logic [9:0] mem_adr;
  logic [7:0] mem_dat_o;
  logic [7:0] mem_dat_i = 8'd0;
  logic       mem_we, busy, wr_done;

  assign scl_w = m_scl;
  assign sda_w = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  always #5 clk = ~clk;

  i2c_eeprom_slave #(.DEVADR_HI(5'b10100), .PAGE_BITS(4)) dut (
    .clock_i  (clk),
    .reset_i  (rst_n),
    .scl      (scl_w),
    .sda      (sda_w),
    .mem_adr_o(mem_adr),
    .mem_dat_o(mem_dat_o),
    .mem_we_o (mem_we),
    .mem_dat_i(mem_dat_i),
    .busy_o   (busy),
    .wr_done_o(wr_done)
  );

  // NOTE: the storage RAM is deliberately never reset, like the real EEPROM array.
  logic [7:0] ram [1024];
  always @(posedge clk) begin
    if (mem_we) ram[mem_adr] <= mem_dat_o;
    mem_dat_i <= ram[mem_adr];
  end

  logic [7:0] ref_mem [1024];
  int         ref_ptr = 0;
  wr_t        exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  event       rd_ev;
  logic [7:0] rd_obs;
  int         n_tests = 0;
  int         n_fail = 0;
  int         wr_done_cnt = 0;
  logic       watch_sda = 1'b0;
  logic       dut_pulled = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_wr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected write: adr 0x%0h data 0x%0h", mem_adr, mem_dat_o);
      end else begin
        wr_t w;
        w = exp_wr_q.pop_front();
        check("write address", mem_adr, w.adr);
        check("write data", mem_dat_o, w.dat);
      end
    end
    if (wr_done) wr_done_cnt++;
    if (watch_sda && sda_w === 1'b0 && !m_sda_low) dut_pulled = 1'b1;
  end

  initial begin
    forever begin
      @(rd_ev);
      if (exp_rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected read byte: 0x%0h", rd_obs);
      end else begin
        check("read data", rd_obs, exp_rd_q.pop_front());
      end
    end
  end

  task automatic half();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; half(); m_scl = 1'b1; half();
    m_sda_low = 1'b1; half(); m_scl = 1'b0; half();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; half(); m_scl = 1'b1; half();
    m_sda_low = 1'b0; half();
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = !b; half(); m_scl = 1'b1; half(); half(); m_scl = 1'b0; half();
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; half(); m_scl = 1'b1; half(); b = sda_w; half(); m_scl = 1'b0; half();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bit_v);
      b[i] = bit_v;
    end
    send_bit(nack);
  endtask

  function automatic int page_next(input int p);
    return (p & ~(PAGE - 1)) | ((p + 1) & (PAGE - 1));
  endfunction

  task automatic tx_write(input logic [1:0] blk, input logic [7:0] word, input logic [7:0] data[$]);
    logic ack;
    int   done0;
    done0 = wr_done_cnt;
    i2c_start();
    wr_byte({DEV_HI, blk, 1'b0}, ack);
    check("device ack (write)", ack, 0);
    check("busy after device ack", busy, 1);
    wr_byte(word, ack);
    check("word address ack", ack, 0);
    ref_ptr = int'(blk) * 256 + int'(word);
    foreach (data[i]) begin
      exp_wr_q.push_back('{adr: ref_ptr, dat: data[i]});
      ref_mem[ref_ptr] = data[i];
      ref_ptr = page_next(ref_ptr);
      wr_byte(data[i], ack);
      check("data ack", ack, 0);
    end
    i2c_stop();
    check("busy after stop", busy, 0);
    check("wr_done pulses", wr_done_cnt - done0, (data.size() > 0) ? 1 : 0);
    check("pointer after write", mem_adr, ref_ptr);
  endtask

  task automatic tx_read(input logic set_addr, input logic [1:0] blk, input logic [7:0] word, input int n);
    logic       ack;
    logic [7:0] b;
    int         done0;
    done0 = wr_done_cnt;
    i2c_start();
    if (set_addr) begin
      wr_byte({DEV_HI, blk, 1'b0}, ack);
      check("device ack (addr phase)", ack, 0);
      wr_byte(word, ack);
      check("word address ack", ack, 0);
      ref_ptr = int'(blk) * 256 + int'(word);
      i2c_start();
    end
    wr_byte({DEV_HI, blk, 1'b1}, ack);
    check("device ack (read)", ack, 0);
    ref_ptr = int'(blk) * 256 + (ref_ptr % 256);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(ref_mem[ref_ptr]);
      ref_ptr = (ref_ptr + 1) % 1024;
      rd_byte(i == n - 1, b);
      rd_obs = b;
      ->rd_ev;
    end
    i2c_stop();
    check("busy after read stop", busy, 0);
    check("no wr_done on read", wr_done_cnt - done0, 0);
    check("pointer after read", mem_adr, ref_ptr);
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic       ack;
    logic [1:0] blk;
    logic [7:0] word;
    int         bad;

    for (int i = 0; i < 1024; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      ram[i] <= v;
      ref_mem[i] = v;
    end

    repeat (4) @(negedge clk);
    check("reset mem_adr_o", mem_adr, 0);
    check("reset mem_dat_o", mem_dat_o, 0);
    check("reset mem_we_o", mem_we, 0);
    check("reset busy_o", busy, 0);
    check("reset wr_done_o", wr_done, 0);
    check("reset sda released", sda_w, 1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Plain page write and random read back
    q = {8'h11, 8'h22, 8'h33};
    tx_write(2'd0, 8'h10, q);
    check("ram[0x010]", ram[10'h010], 8'h11);
    check("ram[0x011]", ram[10'h011], 8'h22);
    check("ram[0x012]", ram[10'h012], 8'h33);
    tx_read(1'b1, 2'd0, 8'h10, 3);
    check("pointer ends at 0x013", mem_adr, 10'h013);

    // Block select and 10-bit pointer wrap on sequential read
    q = {8'h5A};
    tx_write(2'd3, 8'hFF, q);
    check("ram[0x3FF]", ram[10'h3FF], 8'h5A);
    tx_read(1'b1, 2'd3, 8'hFF, 2);

    // Page wrap: 18 bytes starting at 0x0E
    q = {};
    for (int i = 0; i < 18; i++) q.push_back(8'(i));
    tx_write(2'd0, 8'h0E, q);
    check("page wrap ram[0x0E]", ram[10'h00E], 8'd16);
    check("page wrap ram[0x0F]", ram[10'h00F], 8'd17);
    check("page wrap ram[0x00]", ram[10'h000], 8'd2);
    check("page wrap ram[0x0D]", ram[10'h00D], 8'd15);
    check("page wrap ram[0x10] untouched", ram[10'h010], 8'h11);

    // Foreign device address
    watch_sda = 1'b1;
    i2c_start();
    wr_byte(8'h90, ack);
    check("mismatch nack", ack, 1);
    check("mismatch busy", busy, 0);
    wr_byte(8'h55, ack);
    check("mismatch data nack", ack, 1);
    i2c_stop();
    watch_sda = 1'b0;
    check("mismatch never pulled sda", dut_pulled, 0);
    check("pointer after mismatch", mem_adr, ref_ptr);

    // STOP in the middle of a data byte
    begin
      int done0;
      done0 = wr_done_cnt;
      i2c_start();
      wr_byte({DEV_HI, 2'd0, 1'b0}, ack);
      check("abort device ack", ack, 0);
      wr_byte(8'h20, ack);
      check("abort word ack", ack, 0);
      ref_ptr = 10'h020;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      i2c_stop();
      check("abort busy", busy, 0);
      check("abort no wr_done", wr_done_cnt - done0, 0);
      check("abort pointer", mem_adr, 10'h020);
    end
    tx_read(1'b0, 2'd0, 8'h00, 1);

    // Reset while the slave is driving a 0 data bit
    i2c_start();
    wr_byte({DEV_HI, 2'd0, 1'b0}, ack);
    wr_byte(8'h10, ack);
    i2c_start();
    wr_byte({DEV_HI, 2'd0, 1'b1}, ack);
    check("read msb of 0x11 driven low", sda_w, 0);
    rst_n = 1'b0;
    #1;
    check("async reset releases sda", sda_w, 1);
    check("async reset mem_adr_o", mem_adr, 0);
    check("async reset mem_dat_o", mem_dat_o, 0);
    check("async reset busy_o", busy, 0);
    check("async reset mem_we_o", mem_we, 0);
    check("async reset wr_done_o", wr_done, 0);
    ref_ptr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    i2c_stop();
    check("busy after reset recovery", busy, 0);
    check("pointer after reset recovery", mem_adr, 0);

    // Randomized mix of writes, random reads and current-address reads
    for (int t = 0; t < 14; t++) begin
      blk  = 2'($urandom_range(0, 3));
      word = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0: begin
          q = {};
          for (int i = 0; i < int'($urandom_range(1, 6)); i++) q.push_back(8'($urandom));
          tx_write(blk, word, q);
        end
        1: tx_read(1'b1, blk, word, int'($urandom_range(1, 4)));
        default: tx_read(1'b0, blk, 8'h00, int'($urandom_range(1, 4)));
      endcase
    end

    repeat (10) @(negedge clk);
    check("write scoreboard drained", exp_wr_q.size(), 0);
    check("read scoreboard drained", exp_rd_q.size(), 0);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
    check("ram image vs model", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
